// File: rtl/comp_pkg.sv
// comp_pkg: shared types for the pipelined magnitude comparator.
//   comp_mode_e   - decoded per-transaction compare mode
//   comp_result_t - one-hot compare outcome {less, equal, greater, unordered}
package comp_pkg;

    typedef enum logic [1:0] {
        CMP_UNSIGNED = 2'b00,
        CMP_SIGNED   = 2'b01,
        CMP_SIGNMAG  = 2'b10
    } comp_mode_e;

    typedef struct packed {
        logic less;
        logic equal;
        logic greater;
        logic unordered;
    } comp_result_t;

    // Raw i_mode encoding 2'b11 falls back to unsigned.
    function automatic comp_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return CMP_SIGNED;
            2'b10:   return CMP_SIGNMAG;
            default: return CMP_UNSIGNED;
        endcase
    endfunction

endpackage

// File: rtl/comp_block.sv
// comp_block: combinational leaf comparator for one BLOCK_SIZE-bit slice.
//   i_a, i_b  - slice operands (unsigned)
//   o_less    - i_a < i_b
//   o_equal   - i_a == i_b
module comp_block #(
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] i_a,
    input  logic [BLOCK_SIZE-1:0] i_b,
    output logic                  o_less,
    output logic                  o_equal
);

    assign o_less  = (i_a < i_b);
    assign o_equal = (i_a == i_b);

endmodule

// File: rtl/comp_pipe.sv
// comp_pipe: 2-stage pipelined magnitude comparator with valid/ready handshake.
//   Stage 1 runs NUM_BLOCK leaf compares on the magnitude bits; stage 2 reduces them
//   MSB-first and applies the unsigned / two's complement / sign-magnitude rules.
// Ports:
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_valid, o_ready       - input handshake (o_ready is the global advance)
//   i_data_a, i_data_b     - operands
//   i_mode                 - 00 unsigned, 01 signed, 10 sign-magnitude, 11 unsigned
//   o_valid, i_ready       - output handshake
//   o_less/o_equal/o_greater/o_unordered - one-hot result while o_valid
// Optional feature: define COMP_PIPE_NAN_DETECT_EN to flag NaN operands in
//   sign-magnitude mode as unordered; otherwise o_unordered is tied 0.
module comp_pipe
    import comp_pkg::*;
#(
    parameter int unsigned SIZE_DATA  = 32,
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned EXP_WIDTH  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    input  logic [1:0]           i_mode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_less,
    output logic                 o_equal,
    output logic                 o_greater,
    output logic                 o_unordered
);

    localparam int unsigned NUM_BLOCK = SIZE_DATA / BLOCK_SIZE;

    if (SIZE_DATA % BLOCK_SIZE != 0) begin : g_bad_block
        $fatal(1, "comp_pipe: SIZE_DATA must be a multiple of BLOCK_SIZE");
    end
    if (EXP_WIDTH == 0 || EXP_WIDTH >= SIZE_DATA - 1) begin : g_bad_exp
        $fatal(1, "comp_pipe: EXP_WIDTH must leave room for sign and mantissa");
    end

    // ---------------- Stage 1 ----------------
    logic                 w_advance;
    comp_mode_e           w_mode;
    logic                 w_strip_msb;
    logic [SIZE_DATA-1:0] w_mag_a;
    logic [SIZE_DATA-1:0] w_mag_b;
    logic [NUM_BLOCK-1:0] w_blk_lt;
    logic [NUM_BLOCK-1:0] w_blk_eq;
    logic                 w_zero_a;
    logic                 w_zero_b;

    logic                 r_s1_valid;
    logic [NUM_BLOCK-1:0] r_s1_blk_lt;
    logic [NUM_BLOCK-1:0] r_s1_blk_eq;
    logic                 r_s1_sign_a;
    logic                 r_s1_sign_b;
    comp_mode_e           r_s1_mode;
    logic                 r_s1_zero_a;
    logic                 r_s1_zero_b;
    logic                 r_s1_nan_a;
    logic                 r_s1_nan_b;

    logic                 r_s2_valid;
    comp_result_t         r_res;

    assign w_advance   = ~r_s2_valid | i_ready;
    assign w_mode      = decode_mode(i_mode);
    assign w_strip_msb = (w_mode != CMP_UNSIGNED);

    // In signed modes the MSB is a sign bit and must not take part in the leaf compare.
    assign w_mag_a  = {i_data_a[SIZE_DATA-1] & ~w_strip_msb, i_data_a[SIZE_DATA-2:0]};
    assign w_mag_b  = {i_data_b[SIZE_DATA-1] & ~w_strip_msb, i_data_b[SIZE_DATA-2:0]};
    assign w_zero_a = ~|i_data_a[SIZE_DATA-2:0];
    assign w_zero_b = ~|i_data_b[SIZE_DATA-2:0];

    for (genvar g = 0; g < NUM_BLOCK; g++) begin : g_blk
        comp_block #(
            .BLOCK_SIZE (BLOCK_SIZE)
        ) u_blk (
            .i_a     (w_mag_a[g*BLOCK_SIZE +: BLOCK_SIZE]),
            .i_b     (w_mag_b[g*BLOCK_SIZE +: BLOCK_SIZE]),
            .o_less  (w_blk_lt[g]),
            .o_equal (w_blk_eq[g])
        );
    end

`ifdef COMP_PIPE_NAN_DETECT_EN
    localparam int unsigned MAN_WIDTH = SIZE_DATA - 1 - EXP_WIDTH;
    logic w_nan_a;
    logic w_nan_b;
    assign w_nan_a = (w_mode == CMP_SIGNMAG) & (&i_data_a[SIZE_DATA-2 -: EXP_WIDTH])
                     & (|i_data_a[MAN_WIDTH-1:0]);
    assign w_nan_b = (w_mode == CMP_SIGNMAG) & (&i_data_b[SIZE_DATA-2 -: EXP_WIDTH])
                     & (|i_data_b[MAN_WIDTH-1:0]);
`else
    logic w_nan_a;
    logic w_nan_b;
    assign w_nan_a = 1'b0;
    assign w_nan_b = 1'b0;
`endif

    // ---------------- Stage 2 ----------------
    logic         w_mag_lt;
    logic         w_mag_eq;
    logic         w_unord;
    comp_result_t w_res;

    always_comb begin
        // Higher blocks override lower ones, so fold from block 0 upward.
        w_mag_lt = 1'b0;
        for (int i = 0; i < NUM_BLOCK; i++) begin
            w_mag_lt = r_s1_blk_lt[i] | (r_s1_blk_eq[i] & w_mag_lt);
        end
        w_mag_eq = &r_s1_blk_eq;
    end

    always_comb begin
        w_unord       = r_s1_nan_a | r_s1_nan_b;
        w_res         = '0;
        w_res.less    = w_mag_lt;
        w_res.equal   = w_mag_eq;
        case (r_s1_mode)
            CMP_SIGNED: begin
                if (r_s1_sign_a != r_s1_sign_b) begin
                    w_res.less  = r_s1_sign_a;
                    w_res.equal = 1'b0;
                end
            end
            CMP_SIGNMAG: begin
                if (r_s1_zero_a && r_s1_zero_b) begin
                    // +0 == -0
                    w_res.less  = 1'b0;
                    w_res.equal = 1'b1;
                end else if (r_s1_sign_a != r_s1_sign_b) begin
                    w_res.less  = r_s1_sign_a;
                    w_res.equal = 1'b0;
                end else if (r_s1_sign_a) begin
                    // Both negative: larger magnitude is the smaller value.
                    w_res.less  = ~w_mag_lt & ~w_mag_eq;
                    w_res.equal = w_mag_eq;
                end
            end
            default: ;
        endcase
        if (w_unord) begin
            w_res.less  = 1'b0;
            w_res.equal = 1'b0;
        end
        w_res.unordered = w_unord;
        w_res.greater   = ~w_res.less & ~w_res.equal & ~w_unord;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_res      <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= i_valid;
            r_s1_blk_lt <= w_blk_lt;
            r_s1_blk_eq <= w_blk_eq;
            r_s1_sign_a <= i_data_a[SIZE_DATA-1];
            r_s1_sign_b <= i_data_b[SIZE_DATA-1];
            r_s1_mode   <= w_mode;
            r_s1_zero_a <= w_zero_a;
            r_s1_zero_b <= w_zero_b;
            r_s1_nan_a  <= w_nan_a;
            r_s1_nan_b  <= w_nan_b;
            r_s2_valid  <= r_s1_valid;
            // Keep result outputs at zero whenever no valid result is presented.
            r_res       <= r_s1_valid ? w_res : '0;
        end
    end

    assign o_ready     = w_advance;
    assign o_valid     = r_s2_valid;
    assign o_less      = r_res.less;
    assign o_equal     = r_res.equal;
    assign o_greater   = r_res.greater;
    assign o_unordered = r_res.unordered;

endmodule

// File: tb/tb_comp_pipe.sv
// tb_comp_pipe: directed table-driven bench for comp_pipe plus backpressure and
// mid-stream reset sequences. Define COMP_PIPE_NAN_DETECT_EN to cover NaN detect.
module tb_comp_pipe;

    localparam logic [3:0] LT = 4'b1000;
    localparam logic [3:0] EQ = 4'b0100;
    localparam logic [3:0] GT = 4'b0010;
    localparam logic [3:0] UN = 4'b0001;
    localparam int NVEC = 18;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mode;
        logic [3:0]  res;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic [1:0]  i_mode;
    logic        o_valid;
    logic        i_ready;
    logic        o_less;
    logic        o_equal;
    logic        o_greater;
    logic        o_unordered;
    logic [3:0]  w_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[NVEC];

    comp_pipe #(
        .SIZE_DATA  (32),
        .BLOCK_SIZE (4),
        .EXP_WIDTH  (8)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_a    (i_data_a),
        .i_data_b    (i_data_b),
        .i_mode      (i_mode),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_less      (o_less),
        .o_equal     (o_equal),
        .o_greater   (o_greater),
        .o_unordered (o_unordered)
    );

    always #5 i_clk = ~i_clk;

    assign w_out = {o_less, o_equal, o_greater, o_unordered};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int idx);
        i_data_a = vecs[idx].a;
        i_data_b = vecs[idx].b;
        i_mode   = vecs[idx].mode;
    endtask

    // One isolated transaction: not valid after 1 edge, valid with result after 2.
    task automatic run_vec(input int idx);
        @(negedge i_clk);
        drive(idx);
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        check($sformatf("v%0d_lat1_valid", idx), o_valid, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        check($sformatf("v%0d_valid", idx), o_valid, 1);
        check($sformatf("v%0d_result", idx), w_out, vecs[idx].res);
    endtask

    initial begin
        int  sent;
        int  recv;
        logic fire_in;

        vecs[0]  = '{32'h0000_0010, 32'h8000_0000, 2'b00, LT};
        vecs[1]  = '{32'h8000_0000, 32'h0000_0010, 2'b00, GT};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b01, LT};
        vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 2'b01, EQ};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0000, 2'b10, EQ};
        vecs[5]  = '{32'hC000_0000, 32'hBF80_0000, 2'b10, LT};
        vecs[6]  = '{32'h7FC0_0000, 32'h3F80_0000, 2'b00, GT};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b11, GT};
        vecs[8]  = '{32'h0000_0001, 32'hFFFF_FFFF, 2'b01, GT};
        vecs[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 2'b01, LT};
        vecs[10] = '{32'h0000_0005, 32'h8000_0007, 2'b10, GT};
        vecs[11] = '{32'h8000_0005, 32'h8000_0007, 2'b10, GT};
        vecs[12] = '{32'h1234_5678, 32'h1234_5678, 2'b00, EQ};
        vecs[13] = '{32'h1234_5678, 32'h1234_5679, 2'b00, LT};
        vecs[14] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b01, LT};
        vecs[15] = '{32'h0000_0000, 32'h8000_0000, 2'b10, EQ};
        vecs[16] = '{32'h7000_0000, 32'h0FFF_FFFF, 2'b01, GT};
`ifdef COMP_PIPE_NAN_DETECT_EN
        vecs[17] = '{32'h7FC0_0000, 32'h3F80_0000, 2'b10, UN};
`else
        vecs[17] = '{32'h7FC0_0000, 32'h3F80_0000, 2'b10, GT};
`endif

        // Reset
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_data_a = '0;
        i_data_b = '0;
        i_mode   = 2'b00;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_result", w_out, 0);
        i_rst = 1'b0;
        #1;
        check("rst_ready", o_ready, 1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Backpressure: 4 back-to-back transactions, i_ready low in cycles 3-6.
        sent = 0;
        recv = 0;
        for (int c = 0; c < 40 && recv < 4; c++) begin
            @(negedge i_clk);
            i_ready = !(c >= 3 && c <= 6);
            if (sent < 4) begin
                drive(sent);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (c >= 3 && c <= 6) begin
                check($sformatf("bp_stall%0d_valid", c), o_valid, 1);
                check($sformatf("bp_stall%0d_ready", c), o_ready, 0);
                check($sformatf("bp_stall%0d_hold", c), w_out, vecs[1].res);
            end
            if (o_valid && i_ready) begin
                check($sformatf("bp_order%0d", recv), w_out, vecs[recv].res);
                recv++;
            end
            fire_in = i_valid && o_ready;
            @(posedge i_clk);
            if (fire_in) sent++;
        end
        check("bp_recv_count", recv, 4);
        check("bp_sent_count", sent, 4);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("bp_drained", o_valid, 0);

        // Reset with two transactions in flight.
        @(negedge i_clk);
        drive(4);
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        drive(5);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        check("mid_inflight", o_valid, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_result", w_out, 0);
        i_rst = 1'b0;
        #1;
        check("mid_rst_ready", o_ready, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("mid_no_stale", o_valid, 0);
        run_vec(13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule
